// File: rtl/core_pmp_loader.sv
// core_pmp_loader: boot-time sequencer that copies a region table into the
// PMP CSR block. Every pmpaddr and packed pmpcfg write is read back and
// compared. The result is a done pulse or a sticky err.
module core_pmp_loader #(
  parameter int ADDR_WIDTH  = 56,
  parameter int NUM_REGIONS = 8
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [6:0]            err_idx,
  output logic                  tbl_req,
  output logic [5:0]            tbl_idx,
  input  logic                  tbl_ack,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [7:0]            tbl_cfg,
  output logic                  csr_en,
  output logic                  csr_wr,
  output logic                  csr_wr_set,
  output logic                  csr_wr_clr,
  output logic [11:0]           csr_addr,
  output logic [63:0]           csr_wdata,
  input  logic [63:0]           csr_rdata
);

  // Index of the last region. It is clamped so that NUM_REGIONS=0 still
  // elaborates; that case never leaves IDLE for FETCH.
  localparam int         LAST_I = (NUM_REGIONS > 0) ? NUM_REGIONS - 1 : 0;
  localparam logic [5:0] LAST   = LAST_I[5:0];

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WADDR, S_RADDR, S_WCFG, S_RCFG, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            i_q, i_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           shadow_q, shadow_d;
  logic                  err_q, err_d;
  logic [6:0]            err_idx_q, err_idx_d;
  logic [63:0]           addr_ext;

  // The loader never uses the set or clear CSR write forms.
  assign csr_wr_set = 1'b0;
  assign csr_wr_clr = 1'b0;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign err_idx    = err_idx_q;

  // Zero-extend the captured address to the CSR data width.
  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_WIDTH-1:0] = addr_q;
  end

  // Next-state logic and per-state CSR/table drive.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    done      = 1'b0;
    tbl_req   = 1'b0;
    tbl_idx   = '0;
    csr_en    = 1'b0;
    csr_wr    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (NUM_REGIONS == 0) begin
            state_d = S_DONE;
          end else begin
            err_d     = 1'b0;
            err_idx_d = '0;
            i_d       = '0;
            shadow_d  = '0;
            state_d   = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        tbl_req = 1'b1;
        tbl_idx = i_q;
        if (tbl_ack) begin
          addr_d                          = tbl_addr;
          shadow_d[{i_q[2:0], 3'b000} +: 8] = tbl_cfg;
          state_d                         = S_WADDR;
        end
      end
      S_WADDR: begin
        csr_en    = 1'b1;
        csr_wr    = 1'b1;
        csr_addr  = 12'h3B0 + {6'b0, i_q};
        csr_wdata = addr_ext;
        state_d   = S_RADDR;
      end
      S_RADDR: begin
        csr_en   = 1'b1;
        csr_addr = 12'h3B0 + {6'b0, i_q};
        if (csr_rdata[ADDR_WIDTH-1:0] != addr_q) begin
          err_d     = 1'b1;
          err_idx_d = {1'b0, i_q};
          state_d   = S_IDLE;
        end else if (i_q[2:0] == 3'd7 || i_q == LAST) begin
          state_d = S_WCFG;
        end else begin
          i_d     = i_q + 6'd1;
          state_d = S_FETCH;
        end
      end
      S_WCFG: begin
        // The cfg word follows its addresses, so a lock bit set here
        // cannot block any address write of the same group.
        csr_en    = 1'b1;
        csr_wr    = 1'b1;
        csr_addr  = 12'h3A0 + {8'b0, i_q[5:3], 1'b0};
        csr_wdata = shadow_q;
        state_d   = S_RCFG;
      end
      S_RCFG: begin
        csr_en   = 1'b1;
        csr_addr = 12'h3A0 + {8'b0, i_q[5:3], 1'b0};
        if (csr_rdata != shadow_q) begin
          err_d     = 1'b1;
          err_idx_d = {1'b1, 3'b000, i_q[5:3]};
          state_d   = S_IDLE;
        end else if (i_q == LAST) begin
          state_d = S_DONE;
        end else begin
          shadow_d = '0;
          i_d      = i_q + 6'd1;
          state_d  = S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      addr_q    <= '0;
      shadow_q  <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      addr_q    <= addr_d;
      shadow_q  <= shadow_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

endmodule

// File: tb/tb_core_pmp_loader.sv
// Directed bench for core_pmp_loader. Three instances are used: 8, 12 and
// 0 regions. Each has a table model and an echoing PMP CSR model.
module tb_core_pmp_loader;
  localparam int AW = 56;

  logic g_clk = 1'b0;
  logic g_resetn;
  logic [2:0] start, busy, done, err, tbl_req, tbl_ack, csr_en, csr_wr, csr_wr_set, csr_wr_clr;
  logic [2:0][6:0]    err_idx;
  logic [2:0][5:0]    tbl_idx;
  logic [2:0][AW-1:0] tbl_addr;
  logic [2:0][7:0]    tbl_cfg;
  logic [2:0][11:0]   csr_addr;
  logic [2:0][63:0]   csr_wdata, csr_rdata;

  // model state
  logic        clr_log;
  logic [63:0] mem [3][32];
  int          wseq [3][32];
  logic [31:0] acc [3];
  int          wr_cnt [3], req_cnt [3], stall_cnt [3], delay [3];
  logic        unstable [3], prev_req [3];
  logic [5:0]  prev_idx [3];
  logic [2:0]  corrupt_en;
  logic [11:0] corrupt_addr [3];

  int checks = 0, failures = 0;

  always #5 g_clk = ~g_clk;

  core_pmp_loader #(.ADDR_WIDTH(AW), .NUM_REGIONS(8)) u_n8 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .err_idx(err_idx[0]), .tbl_req(tbl_req[0]), .tbl_idx(tbl_idx[0]),
    .tbl_ack(tbl_ack[0]), .tbl_addr(tbl_addr[0]), .tbl_cfg(tbl_cfg[0]), .csr_en(csr_en[0]),
    .csr_wr(csr_wr[0]), .csr_wr_set(csr_wr_set[0]), .csr_wr_clr(csr_wr_clr[0]),
    .csr_addr(csr_addr[0]), .csr_wdata(csr_wdata[0]), .csr_rdata(csr_rdata[0]));

  core_pmp_loader #(.ADDR_WIDTH(AW), .NUM_REGIONS(12)) u_n12 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .err_idx(err_idx[1]), .tbl_req(tbl_req[1]), .tbl_idx(tbl_idx[1]),
    .tbl_ack(tbl_ack[1]), .tbl_addr(tbl_addr[1]), .tbl_cfg(tbl_cfg[1]), .csr_en(csr_en[1]),
    .csr_wr(csr_wr[1]), .csr_wr_set(csr_wr_set[1]), .csr_wr_clr(csr_wr_clr[1]),
    .csr_addr(csr_addr[1]), .csr_wdata(csr_wdata[1]), .csr_rdata(csr_rdata[1]));

  core_pmp_loader #(.ADDR_WIDTH(AW), .NUM_REGIONS(0)) u_n0 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .err(err[2]), .err_idx(err_idx[2]), .tbl_req(tbl_req[2]), .tbl_idx(tbl_idx[2]),
    .tbl_ack(tbl_ack[2]), .tbl_addr(tbl_addr[2]), .tbl_cfg(tbl_cfg[2]), .csr_en(csr_en[2]),
    .csr_wr(csr_wr[2]), .csr_wr_set(csr_wr_set[2]), .csr_wr_clr(csr_wr_clr[2]),
    .csr_addr(csr_addr[2]), .csr_wdata(csr_wdata[2]), .csr_rdata(csr_rdata[2]));

  // Table and PMP read models: region k holds addr 0x1000+k, cfg 0x18|k&7.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      tbl_addr[k] = '0;
      tbl_addr[k][15:0] = 16'h1000 + {10'b0, tbl_idx[k]};
      tbl_cfg[k] = 8'h18 | {5'b0, tbl_idx[k][2:0]};
      tbl_ack[k] = tbl_req[k] && (stall_cnt[k] == delay[k]);
      csr_rdata[k] = (corrupt_en[k] && csr_addr[k] == corrupt_addr[k]) ? 64'h0
                     : mem[k][csr_addr[k][4:0]];
    end
  end

  // PMP write echo and activity log.
  always @(posedge g_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (clr_log) begin
        wr_cnt[k] <= 0; req_cnt[k] <= 0; stall_cnt[k] <= 0; acc[k] <= '0;
        unstable[k] <= 1'b0; prev_req[k] <= 1'b0; prev_idx[k] <= '0;
        for (int a = 0; a < 32; a++) begin
          mem[k][a] <= '0; wseq[k][a] <= 0;
        end
      end else begin
        stall_cnt[k] <= (tbl_req[k] && !tbl_ack[k]) ? stall_cnt[k] + 1 : 0;
        if (tbl_req[k]) req_cnt[k] <= req_cnt[k] + 1;
        if (tbl_req[k] && prev_req[k] && tbl_idx[k] != prev_idx[k]) unstable[k] <= 1'b1;
        prev_req[k] <= tbl_req[k] && !tbl_ack[k];
        prev_idx[k] <= tbl_idx[k];
        if (csr_en[k]) begin
          acc[k][csr_addr[k][4:0]] <= 1'b1;
          if (csr_wr[k]) begin
            mem[k][csr_addr[k][4:0]]  <= csr_wdata[k];
            wseq[k][csr_addr[k][4:0]] <= wr_cnt[k] + 1;
            wr_cnt[k] <= wr_cnt[k] + 1;
          end
        end
      end
    end
  end

  task automatic clear_log();
    clr_log = 1'b1;
    @(posedge g_clk); #1;
    clr_log = 1'b0;
  endtask

  // Pulse start (cycle 0) and follow until idle. Returns the done cycle
  // (0 if none) and the last busy cycle. A second start is pulsed at poke.
  task automatic run(input int k, input int max, input int poke, output int dc, output int lb);
    dc = 0; lb = 0;
    start[k] = 1'b1;
    @(posedge g_clk); #1;
    start[k] = 1'b0;
    for (int n = 1; n <= max; n++) begin
      start[k] = (n == poke);
      if (busy[k]) lb = n;
      if (done[k] && dc == 0) dc = n;
      if (!busy[k]) break;
      @(posedge g_clk); #1;
    end
    start[k] = 1'b0;
    if (busy[k]) begin
      failures++; checks++;
      $display("FAIL run_timeout inst=%0d still busy after %0d cycles", k, max);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, err, tbl_req, csr_en, csr_wr, csr_wr_set, csr_wr_clr} !== 24'h0) begin
      failures++; $display("FAIL reset_ctrl got=%h want=0",
        {busy, done, err, tbl_req, csr_en, csr_wr, csr_wr_set, csr_wr_clr});
    end
    checks++;
    if ({err_idx, tbl_idx, csr_addr} !== '0 || csr_wdata !== '0) begin
      failures++; $display("FAIL reset_data err_idx=%h tbl_idx=%h csr_addr=%h want 0",
        err_idx, tbl_idx, csr_addr);
    end
  endtask

  task automatic test_full_load();
    int dc, lb, bad;
    clear_log();
    run(0, 60, 0, dc, lb);
    checks++; if (dc !== 27) begin failures++; $display("FAIL full_done_cycle got=%0d want=27", dc); end
    checks++; if (lb !== 27) begin failures++; $display("FAIL full_busy_last got=%0d want=27", lb); end
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL full_err got=%b want=0", err[0]); end
    checks++; if (wr_cnt[0] !== 9) begin failures++; $display("FAIL full_wr_cnt got=%0d want=9", wr_cnt[0]); end
    bad = 0;
    for (int r = 0; r < 8; r++)
      if (mem[0][16+r] !== 64'h1000 + 64'(r) || wseq[0][16+r] !== r + 1) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_addr_writes bad=%0d want=0", bad); end
    checks++; if (mem[0][0] !== 64'h1F1E1D1C1B1A1918) begin
      failures++; $display("FAIL full_cfg got=%h want=1f1e1d1c1b1a1918", mem[0][0]); end
    checks++; if (wseq[0][0] !== 9 || acc[0][2] !== 1'b0) begin
      failures++; $display("FAIL full_cfg_order seq=%0d acc3a2=%b want 9/0", wseq[0][0], acc[0][2]); end
  endtask

  task automatic test_table_stall();
    int dc, lb;
    delay[0] = 3;
    clear_log();
    run(0, 80, 0, dc, lb);
    delay[0] = 0;
    checks++; if (dc !== 51) begin failures++; $display("FAIL stall_done_cycle got=%0d want=51", dc); end
    checks++; if (unstable[0] !== 1'b0) begin failures++; $display("FAIL stall_idx_stable got=%b want=0", unstable[0]); end
    checks++; if (req_cnt[0] !== 32) begin failures++; $display("FAIL stall_req_cycles got=%0d want=32", req_cnt[0]); end
    checks++; if (mem[0][0] !== 64'h1F1E1D1C1B1A1918) begin
      failures++; $display("FAIL stall_cfg got=%h want=1f1e1d1c1b1a1918", mem[0][0]); end
  endtask

  task automatic test_addr_mismatch();
    int dc, lb;
    corrupt_addr[0] = 12'h3B2; corrupt_en[0] = 1'b1;
    clear_log();
    run(0, 60, 0, dc, lb);
    corrupt_en[0] = 1'b0;
    checks++; if (err[0] !== 1'b1 || err_idx[0] !== 7'd2) begin
      failures++; $display("FAIL amis_err got=%b/%0d want=1/2", err[0], err_idx[0]); end
    checks++; if (dc !== 0) begin failures++; $display("FAIL amis_done got=%0d want=0", dc); end
    checks++; if (lb !== 9) begin failures++; $display("FAIL amis_last_busy got=%0d want=9", lb); end
    checks++; if (acc[0][19] !== 1'b0 || acc[0][0] !== 1'b0) begin
      failures++; $display("FAIL amis_no_access acc=%h want bits 19,0 clear", acc[0]); end
  endtask

  task automatic test_cfg_mismatch();
    int dc, lb;
    corrupt_addr[1] = 12'h3A2; corrupt_en[1] = 1'b1;
    clear_log();
    run(1, 80, 0, dc, lb);
    corrupt_en[1] = 1'b0;
    checks++; if (err[1] !== 1'b1 || err_idx[1] !== 7'd65) begin
      failures++; $display("FAIL cmis_err got=%b/%0d want=1/65", err[1], err_idx[1]); end
    checks++; if (dc !== 0 || lb !== 40) begin
      failures++; $display("FAIL cmis_timing done=%0d last_busy=%0d want=0/40", dc, lb); end
    checks++; if (mem[1][0] !== 64'h1F1E1D1C1B1A1918 || wseq[1][0] !== 9) begin
      failures++; $display("FAIL cmis_cfg0 got=%h seq=%0d want=1f1e1d1c1b1a1918/9", mem[1][0], wseq[1][0]); end
    checks++; if (mem[1][2] !== 64'h000000001B1A1918 || wseq[1][2] !== 14) begin
      failures++; $display("FAIL cmis_cfg2 got=%h seq=%0d want=1b1a1918/14", mem[1][2], wseq[1][2]); end
  endtask

  task automatic test_zero_regions();
    int dc, lb;
    clear_log();
    run(2, 10, 0, dc, lb);
    checks++; if (dc !== 1 || lb !== 1) begin
      failures++; $display("FAIL zero_timing done=%0d last_busy=%0d want=1/1", dc, lb); end
    checks++; if (wr_cnt[2] !== 0 || acc[2] !== 32'h0 || req_cnt[2] !== 0) begin
      failures++; $display("FAIL zero_activity wr=%0d acc=%h req=%0d want 0", wr_cnt[2], acc[2], req_cnt[2]); end
  endtask

  task automatic test_err_clear();
    int dc, lb;
    clear_log();
    run(0, 60, 0, dc, lb);
    checks++; if (err[0] !== 1'b0 || err_idx[0] !== 7'd0 || dc !== 27) begin
      failures++; $display("FAIL err_clear err=%b idx=%0d done=%0d want 0/0/27", err[0], err_idx[0], dc); end
  endtask

  task automatic test_back_to_back();
    int dc, lb;
    bit found;
    clear_log();
    found = 0;
    start[0] = 1'b1;
    @(posedge g_clk); #1;
    start[0] = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (csr_wr[0] && csr_addr[0] == 12'h3B4) found = 1;
      else begin @(posedge g_clk); #1; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rst_reach_waddr4 got=0 want=1"); end
    #2 g_resetn = 1'b0;
    #1;
    checks++; if ({busy[0], csr_en[0], csr_wr[0]} !== 3'b000) begin
      failures++; $display("FAIL rst_async_drop got=%b want=000", {busy[0], csr_en[0], csr_wr[0]}); end
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    checks++; if ({busy[0], tbl_req[0], err[0]} !== 3'b000) begin
      failures++; $display("FAIL rst_idle got=%b want=000", {busy[0], tbl_req[0], err[0]}); end
    clear_log();
    run(0, 60, 5, dc, lb);
    checks++; if (dc !== 27 || wseq[0][16] !== 1 || wr_cnt[0] !== 9) begin
      failures++; $display("FAIL restart done=%0d seq3b0=%0d wr=%0d want 27/1/9", dc, wseq[0][16], wr_cnt[0]); end
  endtask

  initial begin
    g_resetn = 1'b0; start = '0; clr_log = 1'b1; corrupt_en = '0;
    for (int k = 0; k < 3; k++) begin delay[k] = 0; corrupt_addr[k] = '0; end
    #2;
    test_reset();
    @(posedge g_clk); #1;
    g_resetn = 1'b1; clr_log = 1'b0;
    @(posedge g_clk); #1;
    test_full_load();
    test_table_stall();
    test_addr_mismatch();
    test_cfg_mismatch();
    test_zero_regions();
    test_err_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
